// File: rtl/regfile_bram_mp_if.sv
// Bus bundle for regfile_bram_mp: write port, packed read ports and clear status.
// Debug read port is present only when REGFILE_DEBUG_PORT_EN is defined.
interface regfile_bram_mp_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_READ   = 2
);
   logic                           wr_en;
   logic [ADDR_WIDTH-1:0]          wr_addr;
   logic [DATA_WIDTH-1:0]          wr_data;
   logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
   logic                           init_busy;
`ifdef REGFILE_DEBUG_PORT_EN
   logic [ADDR_WIDTH-1:0]          dbg_addr;
   logic [DATA_WIDTH-1:0]          dbg_data;
`endif

   modport master (
`ifdef REGFILE_DEBUG_PORT_EN
      output dbg_addr,
      input  dbg_data,
`endif
      output wr_en, wr_addr, wr_data, rd_addr,
      input  rd_data, init_busy
   );

   modport slave (
`ifdef REGFILE_DEBUG_PORT_EN
      input  dbg_addr,
      output dbg_data,
`endif
      input  wr_en, wr_addr, wr_data, rd_addr,
      output rd_data, init_busy
   );
endinterface

// File: rtl/regfile_bram_mp.sv
// Multi-read-port register file built from replicated 1R1W RAM banks with a post-reset
// clear sequencer and write-first bypass. REGFILE_DEBUG_PORT_EN adds a debug read bank.
module regfile_bram_mp #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_READ   = 2,
   parameter bit          ZERO_REG   = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   regfile_bram_mp_if.slave bus
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
`ifdef REGFILE_DEBUG_PORT_EN
   localparam int unsigned NUM_BANK = NUM_READ + 1;
`else
   localparam int unsigned NUM_BANK = NUM_READ;
`endif
   localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH:0]    clr_cnt_q, clr_cnt_d;
   logic                   busy_q, busy_d;

   logic                   we_eff;
   logic                   ram_we;
   logic [ADDR_WIDTH-1:0]  ram_waddr;
   logic [DATA_WIDTH-1:0]  ram_wdata;
   logic [ADDR_WIDTH-1:0]  raddr [NUM_BANK];
   logic [NUM_BANK-1:0]    hit_q, hit_d;
   logic [NUM_BANK-1:0]    zero_q, zero_d;
   logic [DATA_WIDTH-1:0]  byp_q, byp_d;
   logic [NUM_BANK-1:0][DATA_WIDTH-1:0] rdata;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      busy_d    = busy_q;
      case (state_q)
         CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d = READY;
               busy_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Clear writes share the bank write port, so they also feed the bypass path;
   // this covers the read sampled on the same edge that clears the last address.
   always_comb begin
      we_eff    = bus.wr_en & ~busy_q & ~(ZERO_REG & (bus.wr_addr == '0));
      ram_we    = busy_q | we_eff;
      ram_waddr = busy_q ? clr_cnt_q[ADDR_WIDTH-1:0] : bus.wr_addr;
      ram_wdata = busy_q ? '0 : bus.wr_data;
      byp_d     = ram_wdata;
   end

   always_comb begin
      for (int unsigned p = 0; p < NUM_READ; p++) begin
         raddr[p] = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
`ifdef REGFILE_DEBUG_PORT_EN
      raddr[NUM_READ] = bus.dbg_addr;
`endif
   end

   always_comb begin
      hit_d  = '0;
      zero_d = '0;
      for (int unsigned b = 0; b < NUM_BANK; b++) begin
         hit_d[b]  = ram_we & (ram_waddr == raddr[b]);
         zero_d[b] = ZERO_REG & (raddr[b] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
         hit_q     <= '0;
         zero_q    <= '0;
         byp_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
         hit_q     <= hit_d;
         zero_q    <= zero_d;
         byp_q     <= byp_d;
      end
   end

   for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] raw_q;

      always_ff @(posedge clk) begin
         if (ram_we) mem[ram_waddr] <= ram_wdata;
         raw_q <= mem[raddr[b]];
      end

      // Raw RAM output is read-before-write; it is only visible when no bypass applies.
      assign rdata[b] = (busy_q | zero_q[b]) ? '0 : (hit_q[b] ? byp_q : raw_q);
   end

   assign bus.init_busy = busy_q;
   assign bus.rd_data   = rdata[NUM_READ-1:0];
`ifdef REGFILE_DEBUG_PORT_EN
   assign bus.dbg_data  = rdata[NUM_READ];
`endif
endmodule

// File: tb/tb_regfile_bram_mp.sv
// Directed self-checking bench for regfile_bram_mp: one instance with ZERO_REG=1, one with 0.
module tb_regfile_bram_mp;
   logic clk;
   logic rst_n;
   int   n_total;
   int   n_bad;
   int   n;

   regfile_bram_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus0 ();
   regfile_bram_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus1 ();

   regfile_bram_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1'b1)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   regfile_bram_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1'b0)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
      bus0.rd_addr = {b, a};
      bus1.rd_addr = {b, a};
   endtask

   task automatic wait_ready(output int cycles);
      cycles = 0;
      while (bus0.init_busy && cycles < 200) begin
         step();
         cycles++;
      end
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
      bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
`ifdef REGFILE_DEBUG_PORT_EN
      bus0.dbg_addr = '0;
      bus1.dbg_addr = '0;
`endif
      set_rd(5'd0, 5'd0);

      step();
      step();
      check("rst_busy", 64'(bus0.init_busy), 64'd1);
      check("rst_rd0", 64'(bus0.rd_data), 64'd0);
      check("rst_rd1", 64'(bus1.rd_data), 64'd0);

      rst_n = 1'b1;
      wait_ready(n);
      check("clr_len", 64'(n), 64'd32);
      check("busy_lo", 64'(bus1.init_busy), 64'd0);

      for (int a = 0; a < 32; a++) begin
         set_rd(5'(a), 5'(31 - a));
         step();
         check("clr_zero", 64'(bus0.rd_data), 64'd0);
      end

      // Plain write then read on both ports
      bus0.wr_en = 1'b1; bus0.wr_addr = 5'd5; bus0.wr_data = 32'hDEADBEEF;
      set_rd(5'd1, 5'd2);
      step();
      bus0.wr_en = 1'b0;
      set_rd(5'd5, 5'd5);
      step();
      check("x5_a", 64'(bus0.rd_data[31:0]), 64'hDEADBEEF);
      check("x5_b", 64'(bus0.rd_data[63:32]), 64'hDEADBEEF);

      // Same-edge write and read: bypass
      bus0.wr_en = 1'b1; bus0.wr_addr = 5'd7; bus0.wr_data = 32'h12345678;
      set_rd(5'd7, 5'd5);
      step();
      check("byp_a", 64'(bus0.rd_data[31:0]), 64'h12345678);
      check("byp_b_x5", 64'(bus0.rd_data[63:32]), 64'hDEADBEEF);
      bus0.wr_addr = 5'd9; bus0.wr_data = 32'h0BADF00D;
      set_rd(5'd9, 5'd7);
      step();
      check("byp_a_x9", 64'(bus0.rd_data[31:0]), 64'h0BADF00D);
      check("ram_b_x7", 64'(bus0.rd_data[63:32]), 64'h12345678);
      bus0.wr_en = 1'b0;
      set_rd(5'd7, 5'd9);
      step();
      check("hold_x7", 64'(bus0.rd_data[31:0]), 64'h12345678);
      check("hold_x9", 64'(bus0.rd_data[63:32]), 64'h0BADF00D);

      // Register 0 behaviour for both ZERO_REG settings
      bus0.wr_en = 1'b1; bus0.wr_addr = 5'd0; bus0.wr_data = 32'hFFFFFFFF;
      bus1.wr_en = 1'b1; bus1.wr_addr = 5'd0; bus1.wr_data = 32'hFFFFFFFF;
      set_rd(5'd0, 5'd0);
      step();
      check("z1_byp", 64'(bus0.rd_data), 64'd0);
      check("z0_byp", 64'(bus1.rd_data), 64'hFFFFFFFF_FFFFFFFF);
      bus0.wr_en = 1'b0;
      bus1.wr_en = 1'b0;
      step();
      check("z1_ram", 64'(bus0.rd_data), 64'd0);
      check("z0_ram", 64'(bus1.rd_data), 64'hFFFFFFFF_FFFFFFFF);

      // Overwrite then boundary address 31
      bus0.wr_en = 1'b1; bus0.wr_addr = 5'd31; bus0.wr_data = 32'h80000001;
      set_rd(5'd1, 5'd1);
      step();
      bus0.wr_addr = 5'd5; bus0.wr_data = 32'h11112222;
      step();
      bus0.wr_en = 1'b0;
      set_rd(5'd5, 5'd31);
      step();
      check("ovw_x5", 64'(bus0.rd_data[31:0]), 64'h11112222);
      check("x31", 64'(bus0.rd_data[63:32]), 64'h80000001);

      // Reset mid-clear restarts the sequence; writes during clear are dropped
      bus0.wr_en = 1'b1; bus0.wr_addr = 5'd3; bus0.wr_data = 32'hA5A5A5A5;
      step();
      bus0.wr_en = 1'b0;
      set_rd(5'd3, 5'd3);
      step();
      check("x3_pre", 64'(bus0.rd_data[31:0]), 64'hA5A5A5A5);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("mid_busy", 64'(bus0.init_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rd", 64'(bus0.rd_data), 64'd0);
      step();
      rst_n = 1'b1;
      bus0.wr_en = 1'b1; bus0.wr_addr = 5'd3; bus0.wr_data = 32'h55555555;
      n = 0;
      while (bus0.init_busy && n < 200) begin
         step();
         n++;
         if (n == 5) check("clr_rd_zero", 64'(bus0.rd_data), 64'd0);
      end
      bus0.wr_en = 1'b0;
      check("restart_len", 64'(n), 64'd32);
      step();
      check("x3_cleared", 64'(bus0.rd_data), 64'd0);

`ifdef REGFILE_DEBUG_PORT_EN
      bus0.wr_en = 1'b1; bus0.wr_addr = 5'd15; bus0.wr_data = 32'h0000BEEF;
      bus0.dbg_addr = 5'd15;
      step();
      check("dbg_byp", 64'(bus0.dbg_data), 64'h0000BEEF);
      bus0.wr_en = 1'b0;
      step();
      check("dbg_ram", 64'(bus0.dbg_data), 64'h0000BEEF);
      bus0.dbg_addr = 5'd3;
      step();
      check("dbg_x3", 64'(bus0.dbg_data), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
